// File: rtl/riscv_ctrl_pkg.sv
// Shared constants for the multi-cycle RISC-V controller.
// Contents: FSM state encoding, major opcodes, ALUOp codes, branch func codes,
// and a helper that identifies opcodes the controller can sequence.
package riscv_ctrl_pkg;

  localparam int unsigned STATE_W  = 3;
  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned FUNC_W   = 3;
  localparam int unsigned ALUOP_W  = 2;

  // FSM state encoding
  localparam logic [STATE_W-1:0] S_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] S_FETCH     = 3'd1;
  localparam logic [STATE_W-1:0] S_DECODE    = 3'd2;
  localparam logic [STATE_W-1:0] S_EXECUTE   = 3'd3;
  localparam logic [STATE_W-1:0] S_MEM       = 3'd4;
  localparam logic [STATE_W-1:0] S_WRITEBACK = 3'd5;

  // Major opcodes (IR[6:0])
  localparam logic [OPCODE_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_IALU   = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;

  // ALUOp encodings seen by the ALU control
  localparam logic [ALUOP_W-1:0] ALU_ADD    = 2'b00;
  localparam logic [ALUOP_W-1:0] ALU_BRANCH = 2'b01;
  localparam logic [ALUOP_W-1:0] ALU_FUNCT  = 2'b10;

  // Branch func (IR[14:12]) encodings
  localparam logic [FUNC_W-1:0] F_BEQ = 3'b000;
  localparam logic [FUNC_W-1:0] F_BLE = 3'b100;
  localparam logic [FUNC_W-1:0] F_BGE = 3'b101;

  // True for opcodes the controller knows how to sequence
  function automatic logic is_legal_op(input logic [OPCODE_W-1:0] op);
    return (op == OP_R) || (op == OP_IALU) || (op == OP_LOAD) ||
           (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/branch_resolve.sv
// Branch condition evaluation from the ALU compare flags.
// Ports:
//   func     - IR[14:12] of the branch
//   alu_zero - rs1 - rs2 == 0
//   alu_lt   - signed rs1 < rs2
//   taken    - combinational branch-taken decision
module branch_resolve
  import riscv_ctrl_pkg::*;
(
  input  logic [FUNC_W-1:0] func,
  input  logic              alu_zero,
  input  logic              alu_lt,
  output logic              taken
);

  // beq / ble / bge; any other func falls through as not taken
  always_comb begin
    taken = 1'b0;
    case (func)
      F_BEQ:   taken = alu_zero;
      F_BLE:   taken = alu_lt | alu_zero;
      F_BGE:   taken = ~alu_lt;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RISC-V control FSM: fetch, decode, execute, memory, writeback.
// Drives datapath control points, PC/IR write strobes, resolves branches and
// counts retired instructions.
// Ports:
//   clk, rst_n            - clock, async active-low reset
//   opcode, func          - IR fields, valid from DECODE onward
//   alu_zero, alu_lt      - ALU compare flags, valid in EXECUTE
//   mem_ready             - memory completes the current access
//   mem_req/mem_we/i_or_d - shared memory port request, write, address select
//   ir_write, pc_write    - IR load and PC+4 strobes (fetch completion)
//   pc_branch             - PC <= branch target
//   alu_src, alu_op       - ALU operand select and operation class
//   reg_write, mem_to_reg - register file write and writeback source
//   retire, illegal       - per-instruction completion / unsupported opcode
//   instret               - retired-instruction counter (wraps)
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNC_W-1:0]   func,
  input  logic                alu_zero,
  input  logic                alu_lt,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                i_or_d,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_branch,
  output logic                alu_src,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic                retire,
  output logic                illegal,
  output logic [CNT_W-1:0]    instret
);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_nxt;
  logic               taken;
  logic               is_r;
  logic               is_ialu;
  logic               is_load;
  logic               is_store;
  logic               is_branch;

  assign is_r      = (opcode == OP_R);
  assign is_ialu   = (opcode == OP_IALU);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);

  branch_resolve u_branch_resolve (
    .func     (func),
    .alu_zero (alu_zero),
    .alu_lt   (alu_lt),
    .taken    (taken)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Retired-instruction counter; natural wrap at 2^CNT_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret <= '0;
    end else if (retire) begin
      instret <= instret + CNT_W'(1);
    end
  end

  // Next-state and control decode; everything defaults low each state
  always_comb begin
    state_nxt  = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_branch  = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    retire     = 1'b0;
    illegal    = 1'b0;

    case (state)
      S_IDLE: begin
        state_nxt = S_FETCH;
      end

      // Instruction fetch from PC; IR and PC+4 commit on the transfer cycle
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          state_nxt = S_DECODE;
        end
      end

      S_DECODE: begin
        if (is_legal_op(opcode)) begin
          state_nxt = S_EXECUTE;
        end else begin
          illegal   = 1'b1;
          state_nxt = S_FETCH;
        end
      end

      // Branches complete here; everything else moves on
      S_EXECUTE: begin
        if (is_branch) begin
          alu_op    = ALU_BRANCH;
          pc_branch = taken;
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end else if (is_load || is_store) begin
          alu_src   = 1'b1;
          alu_op    = ALU_ADD;
          state_nxt = S_MEM;
        end else if (is_r) begin
          alu_op    = ALU_FUNCT;
          state_nxt = S_WRITEBACK;
        end else if (is_ialu) begin
          alu_src   = 1'b1;
          alu_op    = ALU_FUNCT;
          state_nxt = S_WRITEBACK;
        end else begin
          // IR changed under us; abandon and refetch
          state_nxt = S_FETCH;
        end
      end

      // Data access at the ALU-computed address; address generation held
      S_MEM: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        mem_we  = is_store;
        alu_src = 1'b1;
        alu_op  = ALU_ADD;
        if (mem_ready) begin
          if (is_store) begin
            retire    = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_WRITEBACK;
          end
        end
      end

      S_WRITEBACK: begin
        reg_write  = 1'b1;
        mem_to_reg = is_load;
        retire     = 1'b1;
        state_nxt  = S_FETCH;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: a reactive memory model issues
// instructions, a reference model predicts each instruction's outcome, and a
// negedge monitor compares what the controller did per instruction.
module tb_multicycle_ctrl;

  localparam int unsigned CNT_W   = 4;
  localparam int          CNT_MOD = 1 << CNT_W;

  typedef struct {
    logic [6:0] opcode;
    logic [2:0] func;
    logic       zero;
    logic       lt;
    int         fetch_wait;
    int         mem_wait;
  } instr_t;

  typedef struct {
    int         cycles;
    bit         is_illegal;
    bit         taken;
    bit         wr;
    bit         m2r;
    int         xfers;
    bit         we;
    logic [2:0] alu_exe;
    int         instret_before;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [6:0]       opcode = '0;
  logic [2:0]       func = '0;
  logic             alu_zero = 1'b0;
  logic             alu_lt = 1'b0;
  logic             mem_ready = 1'b0;
  logic             mem_req, mem_we, i_or_d, ir_write, pc_write, pc_branch;
  logic             alu_src, reg_write, mem_to_reg, retire, illegal;
  logic [1:0]       alu_op;
  logic [CNT_W-1:0] instret;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  instr_t stim_q[$];
  exp_t   exp_q[$];

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .func       (func),
    .alu_zero   (alu_zero),
    .alu_lt     (alu_lt),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .i_or_d     (i_or_d),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_branch  (pc_branch),
    .alu_src    (alu_src),
    .alu_op     (alu_op),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .retire     (retire),
    .illegal    (illegal),
    .instret    (instret)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [6:0] op);
    return op == 7'b0110011 || op == 7'b0010011 || op == 7'b0000011 ||
           op == 7'b0100011 || op == 7'b1100011;
  endfunction

  function automatic instr_t mk(input logic [6:0] op, input logic [2:0] f, input logic z,
                                input logic l, input int fw, input int mw);
    instr_t t;
    t.opcode = op; t.func = f; t.zero = z; t.lt = l;
    t.fetch_wait = fw; t.mem_wait = mw;
    return t;
  endfunction

  function automatic instr_t rand_instr();
    instr_t t;
    int k;
    int j;
    k = int'($urandom_range(0, 11));
    t.func       = 3'($urandom_range(0, 7));
    t.zero       = 1'($urandom_range(0, 1));
    t.lt         = 1'($urandom_range(0, 1));
    t.fetch_wait = int'($urandom_range(0, 3));
    t.mem_wait   = int'($urandom_range(0, 3));
    if (k < 2)       t.opcode = 7'b0110011;
    else if (k < 4)  t.opcode = 7'b0010011;
    else if (k < 6)  t.opcode = 7'b0000011;
    else if (k < 8)  t.opcode = 7'b0100011;
    else if (k < 11) begin
      t.opcode = 7'b1100011;
      j = int'($urandom_range(0, 3));
      if (j == 0)      t.func = 3'b000;
      else if (j == 1) t.func = 3'b100;
      else if (j == 2) t.func = 3'b101;
    end else begin
      t.opcode = 7'($urandom);
      while (is_legal(t.opcode)) t.opcode = 7'($urandom);
    end
    return t;
  endfunction

  // Reference model: outcome of one instruction from the ISA-level rules
  function automatic exp_t expect_of(input instr_t t, input bit first, input int cnt);
    exp_t e;
    int base;
    e.is_illegal = 0; e.taken = 0; e.wr = 0; e.m2r = 0; e.xfers = 0; e.we = 0;
    e.alu_exe = 3'b000; e.instret_before = cnt;
    case (t.opcode)
      7'b0110011: begin base = 4; e.wr = 1; e.alu_exe = 3'b010; end
      7'b0010011: begin base = 4; e.wr = 1; e.alu_exe = 3'b110; end
      7'b0000011: begin base = 5 + t.mem_wait; e.wr = 1; e.m2r = 1; e.xfers = 1; e.alu_exe = 3'b100; end
      7'b0100011: begin base = 4 + t.mem_wait; e.xfers = 1; e.we = 1; e.alu_exe = 3'b100; end
      7'b1100011: begin
        base = 3; e.alu_exe = 3'b001;
        case (t.func)
          3'b000:  e.taken = t.zero;
          3'b100:  e.taken = t.lt || t.zero;
          3'b101:  e.taken = !t.lt;
          default: e.taken = 0;
        endcase
      end
      default: begin base = 2; e.is_illegal = 1; end
    endcase
    e.cycles = base + t.fetch_wait + (first ? 1 : 0);
    return e;
  endfunction

  // Reactive memory: inserts the instruction's wait states, loads the IR
  // fields after each fetch transfer and records the prediction.
  bit     in_wait = 0;
  bit     fetch_pending = 0;
  bit     first_after_rst = 1;
  int     wait_left = 0;
  int     model_cnt = 0;
  instr_t nxt;
  instr_t cur;

  initial forever begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      in_wait = 0; fetch_pending = 0; first_after_rst = 1; model_cnt = 0; wait_left = 0;
      mem_ready = 1'($urandom_range(0, 1));
    end else begin
      if (fetch_pending) begin
        fetch_pending = 0;
        cur = nxt;
        opcode = cur.opcode; func = cur.func; alu_zero = cur.zero; alu_lt = cur.lt;
        exp_q.push_back(expect_of(cur, first_after_rst, model_cnt));
        first_after_rst = 0;
        if (is_legal(cur.opcode)) model_cnt = (model_cnt + 1) % CNT_MOD;
      end
      if (mem_req) begin
        if (!in_wait) begin
          in_wait = 1;
          if (!i_or_d) begin
            nxt = (stim_q.size() > 0) ? stim_q.pop_front() : rand_instr();
            wait_left = nxt.fetch_wait;
          end else begin
            wait_left = cur.mem_wait;
          end
        end
        if (wait_left > 0) begin
          mem_ready = 1'b0;
          wait_left--;
        end else begin
          mem_ready = 1'b1;
          in_wait = 0;
          if (!i_or_d) fetch_pending = 1;
        end
      end else begin
        in_wait = 0;
        mem_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: accumulate per-instruction observations, compare at completion
  int         obs_cyc, obs_ir, obs_pcw, obs_pcb, obs_wr, obs_xfer;
  bit         obs_m2r, obs_we, decode_quiet;
  logic [2:0] obs_alu, obs_mem_alu, prev_ctl;
  int         since_ir = 99;
  bit         hold_prev = 0;

  task automatic clear_obs();
    obs_cyc = 0; obs_ir = 0; obs_pcw = 0; obs_pcb = 0; obs_wr = 0; obs_xfer = 0;
    obs_m2r = 0; obs_we = 0; decode_quiet = 0; obs_alu = 3'b111; obs_mem_alu = 3'b111;
  endtask

  initial clear_obs();

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
      clear_obs();
      since_ir = 99;
      hold_prev = 0;
    end else begin
      obs_cyc++;
      if (ir_write) begin obs_ir++; since_ir = 0; end
      else if (since_ir < 99) since_ir++;
      if (pc_write) obs_pcw++;
      if (pc_branch) obs_pcb++;
      chk("pc_write_and_branch", 32'(pc_write & pc_branch), 0);
      if (since_ir == 1)
        decode_quiet = !(mem_req | ir_write | pc_write | pc_branch | reg_write | retire |
                         alu_src | (alu_op != 2'b00));
      if (since_ir == 2) obs_alu = {alu_src, alu_op};
      if (reg_write) begin obs_wr++; obs_m2r = mem_to_reg; end
      if (mem_req && i_or_d && mem_ready) begin
        obs_xfer++; obs_we = mem_we; obs_mem_alu = {alu_src, alu_op};
      end
      if (hold_prev) chk("req_stable", 32'({mem_req, mem_we, i_or_d}), 32'(prev_ctl));
      hold_prev = mem_req && !mem_ready;
      prev_ctl  = {mem_req, mem_we, i_or_d};

      if (retire || illegal) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_completion", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("cycles", 32'(obs_cyc), 32'(e.cycles));
          chk("end_kind", 32'({illegal, retire}), e.is_illegal ? 32'd2 : 32'd1);
          chk("ir_write_count", 32'(obs_ir), 1);
          chk("pc_write_count", 32'(obs_pcw), 1);
          chk("pc_branch_count", 32'(obs_pcb), 32'(e.taken));
          chk("reg_write_count", 32'(obs_wr), 32'(e.wr));
          if (e.wr) chk("mem_to_reg", 32'(obs_m2r), 32'(e.m2r));
          chk("data_xfers", 32'(obs_xfer), 32'(e.xfers));
          if (e.xfers != 0) begin
            chk("mem_we", 32'(obs_we), 32'(e.we));
            chk("mem_alu", 32'(obs_mem_alu), 32'b100);
          end
          if (!e.is_illegal) chk("exec_alu", 32'(obs_alu), 32'(e.alu_exe));
          chk("decode_quiet", 32'(decode_quiet), 1);
          chk("instret", 32'(instret), 32'(e.instret_before));
        end
        done_cnt++;
        clear_obs();
      end
    end
  end

  task automatic wait_done(input int target, input int budget, input string name);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(done_cnt >= target), 1);
  endtask

  task automatic chk_all_low(input string name);
    chk(name, 32'({mem_req, mem_we, i_or_d, ir_write, pc_write, pc_branch, alu_src,
                   alu_op, reg_write, mem_to_reg, retire, illegal}), 0);
  endtask

  initial begin
    int n;
    bit seen;
    repeat (3) @(posedge clk);
    #2;
    chk_all_low("reset_outputs");
    chk("reset_instret", 32'(instret), 0);

    // Directed: R, stalled load, taken bge, untaken ble, illegal opcode
    stim_q.push_back(mk(7'b0110011, 3'b000, 0, 0, 0, 0));
    stim_q.push_back(mk(7'b0000011, 3'b010, 0, 0, 2, 3));
    stim_q.push_back(mk(7'b1100011, 3'b101, 0, 0, 0, 0));
    stim_q.push_back(mk(7'b1100011, 3'b100, 0, 0, 0, 0));
    stim_q.push_back(mk(7'b1111111, 3'b000, 0, 0, 0, 0));
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("first_req", 32'(mem_req), 1);
    chk("first_req_from_pc", 32'(i_or_d), 0);
    wait_done(5, 200, "directed_done");

    // Reset while a store waits in MEM
    stim_q.push_back(mk(7'b0100011, 3'b010, 0, 0, 0, 6));
    n = 0;
    seen = 0;
    while (!seen && n < 400) begin
      @(posedge clk);
      #2;
      seen = rst_n && mem_req && i_or_d && mem_we && !mem_ready && wait_left >= 2;
      n++;
    end
    chk("store_wait_reached", 32'(seen), 1);
    rst_n = 1'b0;
    #1;
    chk("reset_drops_req", 32'(mem_req), 0);
    chk("reset_clears_instret", 32'(instret), 0);
    chk_all_low("reset_mid_mem_outputs");
    stim_q.delete();
    repeat (16) stim_q.push_back(mk(7'b0110011, 3'b000, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Sixteen retires from zero wrap the 4-bit counter back to zero
    wait_done(done_cnt + 16, 400, "wrap_done");
    @(negedge clk);
    chk("instret_wrapped", 32'(instret), 0);

    // Random traffic
    wait_done(done_cnt + 80, 3000, "random_done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Finite-state controller that sequences the RISC-V core datapath over multiple cycles: instruction fetch through a shared memory port, decode, execute, data-memory access and register writeback. It supersedes the per-instruction combinational decode for the multi-cycle build and drives the same datapath control points (ALUSrc, MemtoReg, RegWrite, ALUOp, memory enables) plus PC and IR write strobes. It also resolves beq/ble/bge branches and counts retired instructions.

## Interface
- CNT_W, 32, width of retired-instruction counter
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  7  IR[6:0]; valid from DECODE onward
- func  in  3  IR[14:12]; valid from DECODE onward
- alu_zero  in  1  ALU result == 0 (valid in EXECUTE)
- alu_lt  in  1  signed rs1 < rs2 (valid in EXECUTE)
- mem_ready  in  1  memory accepts/completes current access
- mem_req  out  1  memory access request
- mem_we  out  1  request is a write (store)
- i_or_d  out  1  0 = address from PC, 1 = address from ALU result register
- ir_write  out  1  load IR from memory read data
- pc_write  out  1  PC <= PC + 4
- pc_branch  out  1  PC <= branch target
- alu_src  out  1  ALU B operand: 0 = rs2, 1 = immediate
- alu_op  out  2  00 add, 01 branch compare, 10 funct-decoded
- reg_write  out  1  write register file
- mem_to_reg  out  1  writeback source: 1 = memory data, 0 = ALU result
- retire  out  1  one-cycle pulse per completed instruction
- illegal  out  1  one-cycle pulse on unsupported opcode
- instret  out  CNT_W  retired-instruction count

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK.
- IDLE: entered on reset; all outputs 0; next state FETCH unconditionally.
- FETCH: mem_req=1, i_or_d=0, mem_we=0. Hold until mem_ready=1; in that cycle ir_write=1, pc_write=1, go DECODE.
- DECODE: no strobes. Opcode 0110011 (R), 0010011 (I-ALU), 0000011 (load), 0100011 (store), 1100011 (branch) -> EXECUTE; any other -> illegal=1, FETCH (no retire).
- EXECUTE: alu_src=1 and alu_op=10 for I-ALU; alu_src=0, alu_op=10 for R; alu_src=1, alu_op=00 for load/store; alu_src=0, alu_op=01 for branch. R/I-ALU -> WRITEBACK; load/store -> MEM; branch -> retire=1, FETCH.
- Branch resolution in EXECUTE: func 000 beq taken if alu_zero; 100 ble taken if alu_lt or alu_zero; 101 bge taken if !alu_lt; other func not taken. pc_branch=1 only when taken.
- MEM: mem_req=1, i_or_d=1, mem_we=1 for store else 0; alu_op=00, alu_src=1 held. Hold until mem_ready=1; store then retire=1 -> FETCH; load -> WRITEBACK.
- WRITEBACK: reg_write=1; mem_to_reg=1 for load, 0 otherwise; retire=1; -> FETCH.
- instret increments by 1 on every retire cycle, wraps at 2^CNT_W-1 -> 0.
- Outputs not listed for a state are 0.

## Timing
- Reset (async assert): state=IDLE, instret=0, all outputs 0 immediately; any outstanding mem_req dropped, no completion reported.
- First mem_req asserts 1 cycle after rst_n deasserts (IDLE then FETCH).
- Zero-wait latency (mem_ready tied 1): branch 3 cycles, R/I-ALU 4, store 4, load 5. Each wait cycle in FETCH/MEM adds 1.
- Handshake: mem_req, mem_we, i_or_d stable while mem_req=1 and mem_ready=0; transfer occurs in cycle with mem_req && mem_ready. mem_ready outside FETCH/MEM ignored.
- ir_write, pc_write, pc_branch, reg_write, retire, illegal each at most one cycle per instruction; pc_write and pc_branch never both high.
- Outputs are decoded from registered state plus opcode/func/flags/mem_ready; no combinational path from mem_ready to state other than the transition.

## Structure
- Package riscv_ctrl_pkg: state enum, opcode constants (OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH), ALUOp constants, branch func constants (F_BEQ=000, F_BLE=100, F_BGE=101).
- Sub-module branch_resolve: combinational func/alu_zero/alu_lt -> taken.
- Counter and FSM in multicycle_ctrl.

## Test plan
- Reset then R-type (0110011), mem_ready=1 -> mem_req at cycle 1 after reset, reg_write/retire at cycle 4, instret=1.
- Load with mem_ready low 2 cycles in FETCH and 3 in MEM -> 10-cycle instruction, mem_req/i_or_d stable during waits, mem_to_reg=1 at writeback.
- Branch func 101, alu_lt=0 -> pc_branch=1 in EXECUTE; func 100, alu_lt=0, alu_zero=0 -> pc_branch=0; both retire.
- Opcode 1111111 -> illegal pulse in DECODE, next state FETCH, instret unchanged.
- Store, rst_n asserted mid-MEM wait -> mem_req drops same cycle, instret=0, restart via IDLE.
- instret preloaded near wrap (CNT_W=4, 15 retires then 1 more) -> instret reads 0.
